// File: rtl/serial_xfer_pkg.sv
// Shared types and helpers for the serial shift-transfer sequencer.
// Consumed by serial_xfer_div and serial_xfer_ctrl.
package serial_xfer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic DIR_MSB_FIRST = 1'b1;
  localparam logic DIR_LSB_FIRST = 1'b0;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_xfer_div.sv
// Bit-period divider: counts DIV cycles while enabled and flags the last
// (sample) cycle of each period. clr restarts the period at zero.
module serial_xfer_div
  import serial_xfer_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic strobe
);

  localparam int DW = cnt_width(DIV);
  localparam logic [DW-1:0] LAST = DW'(DIV - 1);

  logic [DW-1:0] cnt;

  assign strobe = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/serial_xfer_ctrl.sv
// Full-duplex serial shift sequencer: accepts a word, shifts it out/in one bit
// per DIV cycles in the latched direction. Optional parity bit: SERIAL_XFER_PARITY_EN.
module serial_xfer_ctrl
  import serial_xfer_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DIV   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic             dir,
  input  logic             serial_in,
  output logic             serial_out,
  output logic             bit_strobe,
  output logic             busy,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             parity_err
);

  localparam int BW = cnt_width(WIDTH + 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] tx_sh, rx_sh, rx_nx;
  logic [BW-1:0]    bit_cnt;
  logic             dir_q, accept, strobe, last_bit, div_en;
`ifdef SERIAL_XFER_PARITY_EN
  logic             par_q;
`endif

  assign accept     = tx_valid & tx_ready;
  assign div_en     = (state == SHIFT) || (state == PARITY);
  assign bit_strobe = strobe;
  assign last_bit   = (bit_cnt == BW'(WIDTH - 1));
  assign rx_nx      = (dir_q == DIR_MSB_FIRST) ? {rx_sh[WIDTH-2:0], serial_in}
                                               : {serial_in, rx_sh[WIDTH-1:1]};

  serial_xfer_div #(.DIV(DIV)) u_div (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept),
    .en     (div_en),
    .strobe (strobe)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    tx_ready = 1'b0;
    busy     = 1'b1;
    rx_valid = 1'b0;
    case (state)
      IDLE: begin
        tx_ready = 1'b1;
        busy     = 1'b0;
        if (tx_valid) state_nx = SHIFT;
      end
      SHIFT: begin
`ifdef SERIAL_XFER_PARITY_EN
        if (strobe && last_bit) state_nx = PARITY;
`else
        if (strobe && last_bit) state_nx = DONE;
`endif
      end
      PARITY: if (strobe) state_nx = DONE;
      DONE: begin
        rx_valid = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      serial_out <= 1'b0;
      rx_data    <= '0;
      rx_sh      <= '0;
      tx_sh      <= '0;
      dir_q      <= DIR_LSB_FIRST;
      bit_cnt    <= '0;
`ifdef SERIAL_XFER_PARITY_EN
      par_q      <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else if (accept) begin
      tx_sh      <= tx_data;
      dir_q      <= dir;
      bit_cnt    <= '0;
      serial_out <= (dir == DIR_MSB_FIRST) ? tx_data[WIDTH-1] : tx_data[0];
`ifdef SERIAL_XFER_PARITY_EN
      par_q      <= ^tx_data;
`endif
    end else if (state == SHIFT && strobe) begin
      rx_sh   <= rx_nx;
      bit_cnt <= bit_cnt + 1'b1;
      tx_sh   <= (dir_q == DIR_MSB_FIRST) ? (tx_sh << 1) : (tx_sh >> 1);
      if (last_bit) begin
`ifdef SERIAL_XFER_PARITY_EN
        serial_out <= par_q;
`else
        serial_out <= 1'b0;
        rx_data    <= rx_nx;
`endif
      end else begin
        // next bit is the neighbour of the one currently on the pin
        serial_out <= (dir_q == DIR_MSB_FIRST) ? tx_sh[WIDTH-2] : tx_sh[1];
      end
    end
`ifdef SERIAL_XFER_PARITY_EN
    else if (state == PARITY && strobe) begin
      serial_out <= 1'b0;
      rx_data    <= rx_sh;
      parity_err <= serial_in ^ (^rx_sh);
    end
`endif
  end

`ifndef SERIAL_XFER_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_xfer_ctrl.sv
// Self-checking bench for serial_xfer_ctrl: directed and randomized transfers
// against a cycle-indexed reference model, plus a DIV=1 back-to-back instance.
module tb_serial_xfer_ctrl;

  localparam int W  = 4;
  localparam int DV = 2;
`ifdef SERIAL_XFER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0] tx_data, rx_data;
  logic tx_valid, tx_ready, dir, serial_in, serial_out, bit_strobe, busy, rx_valid, parity_err;
  int   si_mode;
  logic si_drv, inv;

  assign serial_in = (si_mode == 0) ? (serial_out ^ inv) : si_drv;

  serial_xfer_ctrl #(.WIDTH(W), .DIV(DV)) u_dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .dir(dir), .serial_in(serial_in), .serial_out(serial_out), .bit_strobe(bit_strobe),
    .busy(busy), .rx_data(rx_data), .rx_valid(rx_valid), .parity_err(parity_err)
  );

  logic [W-1:0] tx_data1, rx_data1;
  logic tx_valid1, tx_ready1, dir1, serial_out1, bit_strobe1, busy1, rx_valid1, parity_err1;

  serial_xfer_ctrl #(.WIDTH(W), .DIV(1)) u_b2b (
    .clk(clk), .rst(rst), .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
    .dir(dir1), .serial_in(serial_out1), .serial_out(serial_out1), .bit_strobe(bit_strobe1),
    .busy(busy1), .rx_data(rx_data1), .rx_valid(rx_valid1), .parity_err(parity_err1)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] prev_rx = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_tx_ready"},   32'(tx_ready),   32'd1);
    chk({tag, "_busy"},       32'(busy),       32'd0);
    chk({tag, "_serial_out"}, 32'(serial_out), 32'd0);
    chk({tag, "_rx_valid"},   32'(rx_valid),   32'd0);
    chk({tag, "_strobe"},     32'(bit_strobe), 32'd0);
  endtask

  // One transfer. Caller is #1 after an edge with the DUT idle; that cycle is cycle 0.
  // mode: 0 loopback, 1 random serial_in, 2 serial_in forced high.
  task automatic xfer(input logic [W-1:0] d, input logic dr, input int mode,
                      input logic pinv, input logic chaos);
    int t_data, t_done, k;
    logic e_out, rbit, e_perr;
    logic [W-1:0] exp_rx;
    t_data = W * DV;
    t_done = t_data + 1 + PAR * DV;
    exp_rx = '0;
    e_perr = 1'b0;
    si_mode = mode; inv = 1'b0; si_drv = 1'($urandom);
    tx_data = d; dir = dr; tx_valid = 1'b1;
    chk_idle("idle");
    for (int c = 1; c <= t_done; c++) begin
      tick();
      tx_valid = 1'b0;
      if (chaos) begin
        tx_valid = 1'($urandom);
        tx_data  = W'($urandom);
        dir      = 1'($urandom);
      end
      if (c == t_done) tx_valid = 1'b0;
      if (c <= t_data) begin
        k = (c - 1) / DV;
        e_out = dr ? d[W-1-k] : d[k];
      end else begin
        e_out = ^d;
      end
      inv    = (c > t_data) ? pinv : 1'b0;
      si_drv = (mode == 2) ? 1'b1 : 1'($urandom);
      if (c < t_done) begin
        chk("serial_out", 32'(serial_out), 32'(e_out));
        chk("bit_strobe", 32'(bit_strobe), 32'(c % DV == 0));
        chk("busy",       32'(busy),       32'd1);
        chk("tx_ready",   32'(tx_ready),   32'd0);
        chk("rx_valid",   32'(rx_valid),   32'd0);
        chk("rx_hold",    32'(rx_data),    32'(prev_rx));
        if (c % DV == 0) begin
          rbit = (mode == 0) ? (e_out ^ inv) : si_drv;
          if (c <= t_data) begin
            k = (c - 1) / DV;
            if (dr) exp_rx[W-1-k] = rbit;
            else    exp_rx[k]     = rbit;
          end else begin
            e_perr = rbit ^ (^exp_rx);
          end
        end
      end else begin
        chk("done_rx_valid", 32'(rx_valid),   32'd1);
        chk("done_busy",     32'(busy),       32'd1);
        chk("done_strobe",   32'(bit_strobe), 32'd0);
        chk("done_rx_data",  32'(rx_data),    32'(exp_rx));
        chk("parity_err",    32'(parity_err), 32'(PAR == 1 ? e_perr : 1'b0));
        prev_rx = exp_rx;
      end
    end
    tick();
  endtask

  initial begin
    int cyc, last, nacc, rel;
    logic [W-1:0] acc_w;
    tx_data = '0; tx_valid = 1'b0; dir = 1'b0; si_mode = 0; si_drv = 1'b0; inv = 1'b0;
    tx_data1 = '0; tx_valid1 = 1'b0; dir1 = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    chk_idle("reset");
    chk("reset_rx_data",    32'(rx_data),    32'd0);
    chk("reset_parity_err", 32'(parity_err), 32'd0);
    rst = 1'b0;
    tick();

    xfer(4'b1011, 1'b1, 0, 1'b0, 1'b0);
    xfer(4'b1011, 1'b0, 0, 1'b0, 1'b0);
    xfer(4'b0000, 1'b1, 2, 1'b0, 1'b0);
    xfer(4'b1011, 1'b1, 0, 1'b0, 1'b0);
    xfer(4'b1011, 1'b1, 0, 1'b1, 1'b0);
    repeat (14) begin
      xfer(W'($urandom), 1'($urandom), int'($urandom_range(0, 1)), 1'($urandom), 1'b1);
      repeat ($urandom_range(0, 2)) tick();
    end

    // abort mid-transfer; prev_rx is nonzero-likely here so rx_data clearing is visible
    si_mode = 0; inv = 1'b0;
    tx_data = 4'b0110; dir = 1'b1; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk_idle("abort");
    chk("abort_rx_data", 32'(rx_data), 32'd0);
    tick();
    chk("abort_rx_valid", 32'(rx_valid), 32'd0);
    rst = 1'b0;
    prev_rx = '0;
    tick();
    xfer(4'b1101, 1'b0, 0, 1'b0, 1'b0);
    xfer(W'($urandom), 1'b1, 1, 1'b0, 1'b1);
    chk_idle("post");

    // DIV=1 instance with tx_valid held high: one word every W+2 cycles
    cyc = 0; last = 0; nacc = 0; acc_w = '0;
    tx_data1 = W'($urandom); dir1 = 1'($urandom); tx_valid1 = 1'b1;
    repeat (40) begin
      if (tx_ready1) begin
        if (nacc > 0) chk("b2b_gap", 32'(cyc - last), 32'(W + 2));
        chk("b2b_idle_strobe", 32'(bit_strobe1), 32'd0);
        last  = cyc;
        acc_w = tx_data1;
        nacc++;
      end else begin
        rel = cyc - last;
        chk("b2b_strobe", 32'(bit_strobe1), 32'(rel <= W));
        if (rel == W + 1) begin
          chk("b2b_rx_valid", 32'(rx_valid1), 32'd1);
          chk("b2b_rx_data",  32'(rx_data1),  32'(acc_w));
        end
      end
      tick();
      cyc++;
      if (cyc - last == 1) begin
        tx_data1 = W'($urandom);
        dir1     = 1'($urandom);
      end
    end
    tx_valid1 = 1'b0;
    chk("b2b_accepts", 32'(nacc >= 6), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
